// File: rtl/input_mem_sched.sv
// -----------------------------------------------------------------------------
// input_mem_sched
//
// Schedules reads from a bank of SYS_ROW input-memory lanes that feed the rows
// of a systolic array, and forwards host writes into one lane at a time.
//
// A feed sequence is requested with start, and start is only taken in IDLE.
// base_addr and len are captured when start is accepted. The FSM then moves
// through FEED (one read beat per cycle) and DONE (one cycle). A len of 0
// goes straight to DONE and issues no reads.
//
// Optional feature, selected by macro INPUT_MEM_SCHED_SKEW_EN:
//   defined   : diagonal skew. Lane i reads vector k-i in FEED cycle k, so
//               FEED lasts len+SYS_ROW-1 cycles.
//   undefined : all lanes read vector k together, so FEED lasts len cycles.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   start             request a feed sequence (ignored outside IDLE)
//   base_addr, len    first vector address and vector count (0..2^ADDR_WIDTH)
//   busy, done        busy when not IDLE; done is high for the single DONE cycle
//   wr_valid/wr_ready host write handshake (ready only in IDLE without start)
//   wr_row/addr/data  target lane, address and word of a host write
//   mem_rd_en/addr    registered per-lane read port
//   mem_wr_en/addr/data registered per-lane write port
// Lane i occupies bits [(i+1)*W-1 : i*W] of every packed lane bus.
// -----------------------------------------------------------------------------
module input_mem_sched #(
    parameter int SYS_ROW    = 16,
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8,
    localparam int ROW_W     = (SYS_ROW > 1) ? $clog2(SYS_ROW) : 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [ADDR_WIDTH-1:0]          base_addr,
    input  logic [ADDR_WIDTH:0]            len,
    output logic                           busy,
    output logic                           done,
    input  logic                           wr_valid,
    output logic                           wr_ready,
    input  logic [ROW_W-1:0]               wr_row,
    input  logic [ADDR_WIDTH-1:0]          wr_addr,
    input  logic [DATA_WIDTH-1:0]          wr_data,
    output logic [SYS_ROW-1:0]             mem_rd_en,
    output logic [SYS_ROW*ADDR_WIDTH-1:0]  mem_rd_addr,
    output logic [SYS_ROW-1:0]             mem_wr_en,
    output logic [SYS_ROW*ADDR_WIDTH-1:0]  mem_wr_addr,
    output logic [SYS_ROW*DATA_WIDTH-1:0]  mem_wr_data
);

    // The cycle counter has to reach len + SYS_ROW - 2. That is at most
    // 2^ADDR_WIDTH + SYS_ROW, and this width covers it with headroom.
    localparam int KW = ADDR_WIDTH + ROW_W + 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FEED = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                          state_q, state_d;
    logic [KW-1:0]                   k_q, k_d;
    logic [ADDR_WIDTH-1:0]           base_q, base_d;
    logic [ADDR_WIDTH:0]             len_q, len_d;
    logic [SYS_ROW-1:0]              rd_en_q, rd_en_d;
    logic [SYS_ROW*ADDR_WIDTH-1:0]   rd_addr_q, rd_addr_d;
    logic [SYS_ROW-1:0]              wr_en_q, wr_en_d;
    logic [SYS_ROW*ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
    logic [SYS_ROW*DATA_WIDTH-1:0]   wr_data_q, wr_data_d;

    // Inputs to the lane address generator. They describe the FEED cycle the
    // FSM is about to enter, so the read port can be registered and still line
    // up with that cycle.
    logic                            feed_go_s;
    logic [KW-1:0]                   k_sel_s;
    logic [ADDR_WIDTH-1:0]           base_sel_s;
    logic [ADDR_WIDTH:0]             len_sel_s;
    logic [KW-1:0]                   last_k_s;
    logic                            wr_accept_s;

    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_DONE);
    assign wr_ready    = (state_q == ST_IDLE) && !start;
    assign wr_accept_s = wr_valid && wr_ready;

    assign mem_rd_en   = rd_en_q;
    assign mem_rd_addr = rd_addr_q;
    assign mem_wr_en   = wr_en_q;
    assign mem_wr_addr = wr_addr_q;
    assign mem_wr_data = wr_data_q;

`ifdef INPUT_MEM_SCHED_SKEW_EN
    // The last lane starts SYS_ROW-1 cycles late, which stretches FEED by that much.
    assign last_k_s = KW'(len_q) + KW'(SYS_ROW - 1) - KW'(1);
`else
    assign last_k_s = KW'(len_q) - KW'(1);
`endif

    // FSM next state, captured parameters and the next FEED cycle index
    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        base_d     = base_q;
        len_d      = len_q;
        feed_go_s  = 1'b0;
        k_sel_s    = {KW{1'b0}};
        base_sel_s = base_q;
        len_sel_s  = len_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    base_d = base_addr;
                    len_d  = len;
                    k_d    = {KW{1'b0}};
                    if (len == {(ADDR_WIDTH+1){1'b0}}) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d    = ST_FEED;
                        feed_go_s  = 1'b1;
                        base_sel_s = base_addr;
                        len_sel_s  = len;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FEED: begin
                if (k_q == last_k_s) begin
                    state_d = ST_DONE;
                end else begin
                    k_d       = k_q + KW'(1);
                    feed_go_s = 1'b1;
                    k_sel_s   = k_q + KW'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Per-lane read enable and address for FEED cycle k_sel_s
    for (genvar g = 0; g < SYS_ROW; g++) begin : g_lane
        logic                  en_s;
        logic [ADDR_WIDTH-1:0] addr_s;
`ifdef INPUT_MEM_SCHED_SKEW_EN
        logic [KW-1:0]         lane_k_s;
        assign lane_k_s = KW'(g);
        assign en_s     = feed_go_s && (k_sel_s >= lane_k_s) &&
                          (k_sel_s < (lane_k_s + KW'(len_sel_s)));
        // Only the low bits matter, which gives the wrap modulo 2^ADDR_WIDTH.
        assign addr_s   = base_sel_s + k_sel_s[ADDR_WIDTH-1:0] - lane_k_s[ADDR_WIDTH-1:0];
`else
        assign en_s     = feed_go_s && (k_sel_s < KW'(len_sel_s));
        assign addr_s   = base_sel_s + k_sel_s[ADDR_WIDTH-1:0];
`endif
        assign rd_en_d[g]                              = en_s;
        assign rd_addr_d[g*ADDR_WIDTH +: ADDR_WIDTH]   = en_s ? addr_s : {ADDR_WIDTH{1'b0}};
    end

    // Host write fan-out: the address goes to every lane, enable and data to wr_row only
    always_comb begin
        wr_en_d   = {SYS_ROW{1'b0}};
        wr_addr_d = {(SYS_ROW*ADDR_WIDTH){1'b0}};
        wr_data_d = {(SYS_ROW*DATA_WIDTH){1'b0}};
        if (wr_accept_s) begin
            for (int i = 0; i < SYS_ROW; i++) begin
                wr_addr_d[i*ADDR_WIDTH +: ADDR_WIDTH] = wr_addr;
                // An out-of-range row matches no lane, so the write is dropped.
                if (int'(wr_row) == i) begin
                    wr_en_d[i]                            = 1'b1;
                    wr_data_d[i*DATA_WIDTH +: DATA_WIDTH] = wr_data;
                end else begin
                    wr_en_d[i]                            = 1'b0;
                    wr_data_d[i*DATA_WIDTH +: DATA_WIDTH] = {DATA_WIDTH{1'b0}};
                end
            end
        end else begin
            wr_en_d = {SYS_ROW{1'b0}};
        end
    end

    // State, sequence parameters and registered memory ports
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            k_q       <= {KW{1'b0}};
            base_q    <= {ADDR_WIDTH{1'b0}};
            len_q     <= {(ADDR_WIDTH+1){1'b0}};
            rd_en_q   <= {SYS_ROW{1'b0}};
            rd_addr_q <= {(SYS_ROW*ADDR_WIDTH){1'b0}};
            wr_en_q   <= {SYS_ROW{1'b0}};
            wr_addr_q <= {(SYS_ROW*ADDR_WIDTH){1'b0}};
            wr_data_q <= {(SYS_ROW*DATA_WIDTH){1'b0}};
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            base_q    <= base_d;
            len_q     <= len_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

endmodule

// File: tb/tb_input_mem_sched.sv
module tb_input_mem_sched;

    localparam int SR = 4;
    localparam int DW = 16;
    localparam int AW = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [AW-1:0]     base_addr;
    logic [AW:0]       len;
    logic              busy, done;
    logic              wr_valid, wr_ready;
    logic [1:0]        wr_row;
    logic [AW-1:0]     wr_addr;
    logic [DW-1:0]     wr_data;
    logic [SR-1:0]     mem_rd_en;
    logic [SR*AW-1:0]  mem_rd_addr;
    logic [SR-1:0]     mem_wr_en;
    logic [SR*AW-1:0]  mem_wr_addr;
    logic [SR*DW-1:0]  mem_wr_data;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [SR-1:0]    en;
        logic [SR*AW-1:0] addr;
        logic             dn;
    } rd_exp_t;

    typedef struct {
        logic [SR-1:0]    en;
        logic [SR*AW-1:0] addr;
        logic [SR*DW-1:0] data;
    } wr_exp_t;

    rd_exp_t rq[$];
    wr_exp_t wq[$];

    input_mem_sched #(.SYS_ROW(SR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
        .busy(busy), .done(done), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_row(wr_row), .wr_addr(wr_addr), .wr_data(wr_data),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
        .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected read port contents in FEED cycle k
    function automatic rd_exp_t feed_beat(input int k, input int b, input int l);
        rd_exp_t e;
        logic [AW-1:0] a;
        e.en = '0; e.addr = '0; e.dn = 1'b0;
        for (int i = 0; i < SR; i++) begin
`ifdef INPUT_MEM_SCHED_SKEW_EN
            if (k >= i && k < i + l) begin
                a = AW'(b + k - i);
`else
            if (k < l) begin
                a = AW'(b + k);
`endif
                e.en[i] = 1'b1;
                e.addr[i*AW +: AW] = a;
            end
        end
        return e;
    endfunction

    task automatic push_seq(input int b, input int l);
        int n;
        rd_exp_t e;
`ifdef INPUT_MEM_SCHED_SKEW_EN
        n = (l == 0) ? 0 : l + SR - 1;
`else
        n = l;
`endif
        for (int k = 0; k < n; k++) rq.push_back(feed_beat(k, b, l));
        e.en = '0; e.addr = '0; e.dn = 1'b1;
        rq.push_back(e);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || rq.size() != 0) && n < 600) begin
            @(negedge clk);
            n++;
        end
        chk("seq_timeout", 64'(n >= 600), 64'd0);
    endtask

    task automatic run_seq(input int b, input int l);
        @(posedge clk); #1;
        start = 1'b1; base_addr = AW'(b); len = (AW+1)'(l);
        push_seq(b, l);
        @(posedge clk); #1;
        start = 1'b0;
        wait_idle();
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a read beat or a write
    always @(negedge clk) begin
        if (!rst) begin
            if (busy) begin
                if (rq.size() == 0) begin
                    chk("rd_unexpected_busy", 64'(busy), 64'd0);
                end else begin
                    rd_exp_t e;
                    e = rq.pop_front();
                    chk("rd_en", 64'(mem_rd_en), 64'(e.en));
                    chk("rd_addr", 64'(mem_rd_addr), 64'(e.addr));
                    chk("done", 64'(done), 64'(e.dn));
                end
            end else begin
                chk("idle_rd_en", 64'(mem_rd_en), 64'd0);
                chk("idle_done", 64'(done), 64'd0);
            end
            if (mem_wr_en != '0) begin
                if (wq.size() == 0) begin
                    chk("wr_unexpected", 64'(mem_wr_en), 64'd0);
                end else begin
                    wr_exp_t w;
                    w = wq.pop_front();
                    chk("wr_en", 64'(mem_wr_en), 64'(w.en));
                    chk("wr_addr", 64'(mem_wr_addr), 64'(w.addr));
                    chk("wr_data", 64'(mem_wr_data), 64'(w.data));
                end
            end
        end
    end

    initial begin
        wr_exp_t w;
        rst = 1'b1; start = 1'b0; base_addr = '0; len = '0;
        wr_valid = 1'b0; wr_row = '0; wr_addr = '0; wr_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_rd_en", 64'(mem_rd_en), 64'd0);
        chk("rst_rd_addr", 64'(mem_rd_addr), 64'd0);
        chk("rst_wr_en", 64'(mem_wr_en), 64'd0);
        chk("rst_wr_data", 64'(mem_wr_data), 64'd0);
        rst = 1'b0;
        #1 chk("wr_ready_after_rst", 64'(wr_ready), 64'd1);

        run_seq(10, 3);
        run_seq(254, 4);
        run_seq(0, 0);
        run_seq(200, 256);

        // Start and write in the same IDLE cycle: start wins
        @(posedge clk); #1;
        start = 1'b1; base_addr = 8'd7; len = 9'd0;
        wr_valid = 1'b1; wr_row = 2'd1; wr_addr = 8'd3; wr_data = 16'h1234;
        push_seq(7, 0);
        #1 chk("wr_ready_vs_start", 64'(wr_ready), 64'd0);
        @(posedge clk); #1;
        start = 1'b0; wr_valid = 1'b0;
        wait_idle();

        // Write to lane 2 once idle again
        @(posedge clk); #1;
        wr_valid = 1'b1; wr_row = 2'd2; wr_addr = 8'd5; wr_data = 16'hBEEF;
        w.en = 4'b0100;
        w.addr = {8'd5, 8'd5, 8'd5, 8'd5};
        w.data = {16'h0000, 16'hBEEF, 16'h0000, 16'h0000};
        wq.push_back(w);
        #1 chk("wr_ready_idle", 64'(wr_ready), 64'd1);
        @(posedge clk); #1;
        wr_valid = 1'b0;
        repeat (2) @(posedge clk);

        // A write offered during FEED is not taken
        @(posedge clk); #1;
        start = 1'b1; base_addr = 8'd0; len = 9'd2;
        push_seq(0, 2);
        @(posedge clk); #1;
        start = 1'b0;
        wr_valid = 1'b1; wr_row = 2'd3; wr_addr = 8'd9; wr_data = 16'h5555;
        #1 chk("wr_ready_busy", 64'(wr_ready), 64'd0);
        @(posedge clk); #1;
        wr_valid = 1'b0;
        wait_idle();

        // Reset during FEED cycle 2
        @(posedge clk); #1;
        start = 1'b1; base_addr = 8'd20; len = 9'd5;
        push_seq(20, 5);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        chk("midrst_rd_en", 64'(mem_rd_en), 64'd0);
        chk("midrst_rd_addr", 64'(mem_rd_addr), 64'd0);
        rq.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("midrst_wr_ready", 64'(wr_ready), 64'd1);
        chk("midrst_idle", 64'(busy), 64'd0);
        run_seq(100, 2);

        repeat (3) @(posedge clk);
        chk("rd_queue_empty", 64'(rq.size()), 64'd0);
        chk("wr_queue_empty", 64'(wq.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
